// File: rtl/alu_vec_pkg.sv
// Shared opcode and flag types for the vector ALU pipeline and its lanes.
package alu_vec_pkg;

    localparam int OP_WIDTH = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD  = 3'b000,
        OP_OR   = 3'b001,
        OP_AND  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MUL  = 3'b100,
        OP_RSV5 = 3'b101,
        OP_RSV6 = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_vec_lane.sv
// One combinational ALU lane with N/Z/C/V flags.
// Define ALU_VEC_SAT_EN to make ADD/SUB saturate on signed overflow instead of wrapping.
module alu_vec_lane
    import alu_vec_pkg::*;
#(
    parameter int N = 18
) (
    input  logic [OP_WIDTH-1:0] op,
    input  logic [N-1:0]        a,
    input  logic [N-1:0]        b,
    input  logic                mask,
    output logic [N-1:0]        result,
    output flags_t              flags
);

    op_e            opc;
    logic [N:0]     sum;
    logic [2*N-1:0] prod;
    logic [N-1:0]   raw;
    logic           carry;
    logic           ovf;
    logic           arith;

    assign opc  = op_e'(op);
    assign prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};

    // Subtraction reuses the adder as a + ~b + 1, so C means "no borrow".
    always_comb begin
        sum    = '0;
        raw    = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        arith  = 1'b0;
        result = '0;
        flags  = '0;
        case (opc)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                arith = 1'b1;
                ovf   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                sum   = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
                arith = 1'b1;
                ovf   = (a[N-1] != b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_OR:   raw = a | b;
            OP_AND:  raw = a & b;
            OP_MUL: begin
                raw = prod[N-1:0];
                ovf = |prod[2*N-1:N];
            end
            OP_PASS: raw = a;
            default: raw = '0;
        endcase
        if (arith) begin
            carry = sum[N];
            raw   = sum[N-1:0];
`ifdef ALU_VEC_SAT_EN
            // Overflow direction follows the sign of a in both ADD and SUB.
            if (ovf) begin
                raw = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
            end
`else
`endif
        end
        if (mask) begin
            result = raw;
            flags  = '{n: raw[N-1], z: (raw == '0), c: carry, v: ovf};
        end else begin
            result = a;
            flags  = '0;
        end
    end

endmodule

// File: rtl/alu_vector_pipe.sv
// LANES-wide SIMD ALU, two registered stages with valid/ready on both sides.
// Lane arithmetic saturates when ALU_VEC_SAT_EN is defined (see alu_vec_lane).
module alu_vector_pipe
    import alu_vec_pkg::*;
#(
    parameter int N     = 18,
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [LANES*N-1:0]    a,
    input  logic [LANES*N-1:0]    b,
    input  logic [LANES-1:0]      lane_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*N-1:0]    result,
    output logic [LANES-1:0]      flag_n,
    output logic [LANES-1:0]      flag_z,
    output logic [LANES-1:0]      flag_c,
    output logic [LANES-1:0]      flag_v
);

    logic                  s1_valid;
    logic [OP_WIDTH-1:0]   s1_op;
    logic [LANES*N-1:0]    s1_a;
    logic [LANES*N-1:0]    s1_b;
    logic [LANES-1:0]      s1_mask;

    logic                  s2_valid;
    logic [LANES*N-1:0]    s2_result;
    logic [LANES-1:0]      s2_n, s2_z, s2_c, s2_v;

    logic [LANES*N-1:0]    lane_result;
    flags_t                lane_flags [LANES];
    logic [LANES-1:0]      lane_n, lane_z, lane_c, lane_v;

    logic                  adv1, adv2;

    // Each stage advances when it is empty or the stage after it is moving.
    assign adv2     = ~s2_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        alu_vec_lane #(.N(N)) u_lane (
            .op     (s1_op),
            .a      (s1_a[i*N +: N]),
            .b      (s1_b[i*N +: N]),
            .mask   (s1_mask[i]),
            .result (lane_result[i*N +: N]),
            .flags  (lane_flags[i])
        );
        assign lane_n[i] = lane_flags[i].n;
        assign lane_z[i] = lane_flags[i].z;
        assign lane_c[i] = lane_flags[i].c;
        assign lane_v[i] = lane_flags[i].v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_mask   <= '0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_n      <= '0;
            s2_z      <= '0;
            s2_c      <= '0;
            s2_v      <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op   <= op;
                    s1_a    <= a;
                    s1_b    <= b;
                    s1_mask <= lane_mask;
                end
            end
            // Result registers only load real bundles so a stalled output stays put.
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result <= lane_result;
                    s2_n      <= lane_n;
                    s2_z      <= lane_z;
                    s2_c      <= lane_c;
                    s2_v      <= lane_v;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign result    = s2_result;
    assign flag_n    = s2_n;
    assign flag_z    = s2_z;
    assign flag_c    = s2_c;
    assign flag_v    = s2_v;

endmodule

// File: tb/tb_alu_vector_pipe.sv
// Self-checking bench for alu_vector_pipe (N=18, LANES=4) against an arithmetic reference model.
module tb_alu_vector_pipe;

    localparam int N     = 18;
    localparam int LANES = 4;
    localparam int W     = N * LANES;
    localparam int OBS   = W + 4 * LANES;
    localparam longint MOD  = 64'd1 << N;
    localparam longint HALF = 64'd1 << (N - 1);
    localparam longint SMAX = HALF - 1;
    localparam longint SMIN = -HALF;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [LANES-1:0] lane_mask;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [LANES-1:0] flag_n, flag_z, flag_c, flag_v;

    int tests = 0;
    int fails = 0;

    alu_vector_pipe #(.N(N), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .lane_mask (lane_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: true integer arithmetic on unsigned and signed lane values.
    function automatic logic [OBS-1:0] model(input logic [2:0] o, input logic [W-1:0] va,
                                             input logic [W-1:0] vb, input logic [LANES-1:0] m);
        logic [W-1:0]     r;
        logic [LANES-1:0] fn, fz, fc, fv;
        longint ua, ub, sa, sb, full, ss, res;
        bit c, v;
        r = '0; fn = '0; fz = '0; fc = '0; fv = '0;
        for (int i = 0; i < LANES; i++) begin
            ua = longint'(va[i*N +: N]);
            ub = longint'(vb[i*N +: N]);
            sa = (ua >= HALF) ? ua - MOD : ua;
            sb = (ub >= HALF) ? ub - MOD : ub;
            c = 1'b0; v = 1'b0; res = 0; full = 0; ss = 0;
            case (o)
                3'd0: begin
                    full = ua + ub;
                    res  = full % MOD;
                    c    = (full >= MOD);
                    ss   = sa + sb;
                    v    = (ss > SMAX) || (ss < SMIN);
`ifdef ALU_VEC_SAT_EN
                    if (v) res = (ss > SMAX) ? SMAX : MOD + SMIN;
`endif
                end
                3'd3: begin
                    full = ua + (MOD - 1 - ub) + 1;
                    res  = full % MOD;
                    c    = (full >= MOD);
                    ss   = sa - sb;
                    v    = (ss > SMAX) || (ss < SMIN);
`ifdef ALU_VEC_SAT_EN
                    if (v) res = (ss > SMAX) ? SMAX : MOD + SMIN;
`endif
                end
                3'd1: res = ua | ub;
                3'd2: res = ua & ub;
                3'd4: begin
                    full = ua * ub;
                    res  = full % MOD;
                    v    = (full >= MOD);
                end
                3'd7: res = ua;
                default: res = 0;
            endcase
            if (m[i]) begin
                r[i*N +: N] = res[N-1:0];
                fn[i] = (res >= HALF);
                fz[i] = (res == 0);
                fc[i] = c;
                fv[i] = v;
            end else begin
                r[i*N +: N] = va[i*N +: N];
            end
        end
        return {r, fn, fz, fc, fv};
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] x;
        for (int i = 0; i < LANES; i++) x[i*N +: N] = N'($urandom);
        return x;
    endfunction

    // Drives one bundle into an idle pipe and returns the first output bundle seen.
    task automatic run_one(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [LANES-1:0] m, output logic [OBS-1:0] obs, output bit to);
        int n;
        obs = '0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = o;
        a         = va;
        b         = vb;
        lane_mask = m;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        to  = !out_valid;
        obs = {result, flag_n, flag_z, flag_c, flag_v};
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; lane_mask = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({out_valid, result, flag_n, flag_z, flag_c, flag_v} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs got valid=%b res=%h n=%h z=%h c=%h v=%h want all 0",
                     out_valid, result, flag_n, flag_z, flag_c, flag_v);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL reset_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        logic [W-1:0] va, vb;
        logic [OBS-1:0] obs, exp;
        bit to;
        logic [N+2:0] want;
        va = rand_vec(); vb = rand_vec();
        va[N-1:0] = 18'h1FFFF;
        vb[N-1:0] = 18'h00001;
        exp = model(3'd0, va, vb, 4'hF);
        run_one(3'd0, va, vb, 4'hF, obs, to);
        tests++;
        if (to || obs !== exp) begin
            fails++;
            $display("[TB] FAIL add_bundle got=%h want=%h timeout=%0d", obs, exp, to);
        end
`ifdef ALU_VEC_SAT_EN
        want = {18'h1FFFF, 1'b0, 1'b0, 1'b1};
`else
        want = {18'h20000, 1'b1, 1'b0, 1'b1};
`endif
        tests++;
        if ({obs[16 +: N], obs[12], obs[4], obs[0]} !== want) begin
            fails++;
            $display("[TB] FAIL add_lane0_overflow got res/n/c/v=%h want %h",
                     {obs[16 +: N], obs[12], obs[4], obs[0]}, want);
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] va, vb;
        logic [OBS-1:0] obs, exp;
        bit to;
        va = rand_vec(); vb = rand_vec();
        va[N-1:0] = 18'd5; vb[N-1:0] = 18'd5;
        va[2*N-1:N] = 18'd0; vb[2*N-1:N] = 18'd1;
        exp = model(3'd3, va, vb, 4'hF);
        run_one(3'd3, va, vb, 4'hF, obs, to);
        tests++;
        if (to || obs !== exp) begin
            fails++;
            $display("[TB] FAIL sub_bundle got=%h want=%h timeout=%0d", obs, exp, to);
        end
        tests++;
        if ({obs[16 +: N], obs[8], obs[4], obs[0]} !== {18'h0, 3'b110}) begin
            fails++;
            $display("[TB] FAIL sub_equal got res/z/c/v=%h want %h",
                     {obs[16 +: N], obs[8], obs[4], obs[0]}, {18'h0, 3'b110});
        end
        tests++;
        if ({obs[16+N +: N], obs[13], obs[5], obs[1]} !== {18'h3FFFF, 3'b100}) begin
            fails++;
            $display("[TB] FAIL sub_borrow got res/n/c/v=%h want %h",
                     {obs[16+N +: N], obs[13], obs[5], obs[1]}, {18'h3FFFF, 3'b100});
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] va, vb;
        logic [OBS-1:0] obs, exp;
        bit to;
        va = rand_vec(); vb = rand_vec();
        va[N-1:0] = 18'h200; vb[N-1:0] = 18'h200;
        va[2*N-1:N] = 18'd3; vb[2*N-1:N] = 18'd7;
        exp = model(3'd4, va, vb, 4'hF);
        run_one(3'd4, va, vb, 4'hF, obs, to);
        tests++;
        if (to || obs !== exp) begin
            fails++;
            $display("[TB] FAIL mul_bundle got=%h want=%h timeout=%0d", obs, exp, to);
        end
        tests++;
        if ({obs[16 +: N], obs[8], obs[0], obs[16+N +: N], obs[9], obs[1]} !==
            {18'h0, 2'b11, 18'd21, 2'b00}) begin
            fails++;
            $display("[TB] FAIL mul_lanes got=%h want=%h",
                     {obs[16 +: N], obs[8], obs[0], obs[16+N +: N], obs[9], obs[1]},
                     {18'h0, 2'b11, 18'd21, 2'b00});
        end
    endtask

    task automatic test_mask();
        logic [OBS-1:0] obs, exp;
        bit to;
        exp = model(3'd0, {4{18'd10}}, {4{18'd1}}, 4'b0101);
        run_one(3'd0, {4{18'd10}}, {4{18'd1}}, 4'b0101, obs, to);
        tests++;
        if (to || obs !== exp) begin
            fails++;
            $display("[TB] FAIL mask_bundle got=%h want=%h timeout=%0d", obs, exp, to);
        end
        tests++;
        if (obs !== {18'd10, 18'd11, 18'd10, 18'd11, 16'h0000}) begin
            fails++;
            $display("[TB] FAIL mask_lanes got=%h want=%h", obs,
                     {18'd10, 18'd11, 18'd10, 18'd11, 16'h0000});
        end
    endtask

    task automatic test_reserved();
        logic [OBS-1:0] obs;
        bit to;
        for (int k = 5; k <= 6; k++) begin
            run_one(3'(k), rand_vec(), rand_vec(), 4'hF, obs, to);
            tests++;
            if (to || obs !== {72'h0, 4'h0, 4'hF, 4'h0, 4'h0}) begin
                fails++;
                $display("[TB] FAIL reserved_op%0d got=%h want=%h", k, obs,
                         {72'h0, 4'h0, 4'hF, 4'h0, 4'h0});
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] va, vb;
        logic [2:0] o;
        logic [LANES-1:0] m;
        logic [OBS-1:0] obs, exp;
        bit to;
        for (int k = 0; k < 30; k++) begin
            va = rand_vec(); vb = rand_vec();
            o  = 3'($urandom_range(0, 7));
            m  = 4'($urandom_range(0, 15));
            exp = model(o, va, vb, m);
            run_one(o, va, vb, m, obs, to);
            tests++;
            if (to || obs !== exp) begin
                fails++;
                $display("[TB] FAIL random_%0d op=%0d got=%h want=%h timeout=%0d", k, o, obs, exp, to);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ba [8];
        logic [W-1:0] bb [8];
        logic [2:0] bo [8];
        logic [LANES-1:0] bm [8];
        logic [OBS-1:0] q [$];
        int sent, got, cyc, stall, extra;
        for (int i = 0; i < 8; i++) begin
            ba[i] = rand_vec(); bb[i] = rand_vec();
            bo[i] = 3'($urandom_range(0, 7));
            bm[i] = 4'($urandom_range(0, 15));
        end
        sent = 0; got = 0; cyc = 0; stall = 0;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                op = bo[sent]; a = ba[sent]; b = bb[sent]; lane_mask = bm[sent];
            end
            #1;
            if (out_valid) begin
                tests++;
                if (q.size() == 0 || {result, flag_n, flag_z, flag_c, flag_v} !== q[0]) begin
                    fails++;
                    $display("[TB] FAIL b2b_out cyc=%0d got=%h want=%h pending=%0d", cyc,
                             {result, flag_n, flag_z, flag_c, flag_v},
                             (q.size() > 0) ? q[0] : '0, q.size());
                end
                if (out_ready) begin
                    if (q.size() > 0) void'(q.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(bo[sent], ba[sent], bb[sent], bm[sent]));
                sent++;
            end else if (in_valid) begin
                stall++;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (got != 8 || sent != 8 || q.size() != 0) begin
            fails++;
            $display("[TB] FAIL b2b_count got sent=%0d emitted=%0d pending=%0d want 8 8 0",
                     sent, got, q.size());
        end
        tests++;
        if (stall == 0) begin
            fails++;
            $display("[TB] FAIL b2b_backpressure got stall_cycles=%0d want >0", stall);
        end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("[TB] FAIL b2b_duplicate got extra_outputs=%0d want 0", extra);
        end
    endtask

    task automatic test_rst_flush();
        int seen;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1; op = 3'd0; a = rand_vec(); b = rand_vec(); lane_mask = 4'hF;
        @(negedge clk);
        op = 3'd4; a = rand_vec(); b = rand_vec();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL flush_inflight got out_valid=%b want 1", out_valid);
        end
        rst = 1'b1;
        op = 3'd7; a = rand_vec();
        @(negedge clk);
        rst = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests++;
        if ({out_valid, result, flag_n, flag_z, flag_c, flag_v} !== '0) begin
            fails++;
            $display("[TB] FAIL flush_clear got valid=%b res=%h n=%h z=%h c=%h v=%h want all 0",
                     out_valid, result, flag_n, flag_z, flag_c, flag_v);
        end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("[TB] FAIL flush_stale got outputs=%0d want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_mask();
        test_reserved();
        test_random();
        test_back_to_back();
        test_rst_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
